// File: rtl/serializer_sched_pkg.sv
// Shared types and sizing helpers for the serializer frame scheduler and its arbiter.
package serializer_sched_pkg;

  typedef enum logic {
    ST_OFF = 1'b0,
    ST_RUN = 1'b1
  } sched_state_e;

  // A single requester still needs a one-bit owner field.
  function automatic int owner_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_width(input int n);
    return $clog2(n);
  endfunction

  localparam int DEFAULT_INPUTS_NUM = 256;
  localparam int DEFAULT_CNT_W      = $clog2(DEFAULT_INPUTS_NUM);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above ptr, wrapping.
module rr_arbiter
  import serializer_sched_pkg::*;
#(
  parameter  int REQ_NUM = 4,
  localparam int IDX_W   = owner_width(REQ_NUM)
) (
  input  logic [REQ_NUM-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               en,
  output logic [REQ_NUM-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_grant
);

  always_comb begin
    int k;
    k         = 0;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    if (en) begin
      for (int i = 0; i < REQ_NUM; i++) begin
        k = (int'(ptr) + i) % REQ_NUM;
        if (!any_grant && req[k]) begin
          grant[k]  = 1'b1;
          grant_idx = IDX_W'(k);
          any_grant = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/serializer_frame_scheduler.sv
// Time-slots the shared tree serializer among REQ_NUM requesters, one word per
// INPUTS_NUM-cycle slot, and tags the serial line with the delayed slot owner.
module serializer_frame_scheduler
  import serializer_sched_pkg::*;
#(
  parameter  int                    INPUTS_NUM   = 256,
  parameter  int                    REQ_NUM      = 4,
  parameter  int                    TREE_LATENCY = 8,
  parameter  logic [INPUTS_NUM-1:0] IDLE_WORD    = '0,
  localparam int                    OWN_W        = owner_width(REQ_NUM)
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          ENABLE,
  input  logic [REQ_NUM-1:0]            REQ_VALID,
  input  logic [REQ_NUM*INPUTS_NUM-1:0] REQ_DATA,
  output logic [REQ_NUM-1:0]            REQ_READY,
  output logic [INPUTS_NUM-1:0]         PAR_OUT,
  output logic                          FRAME_START,
  output logic                          SLOT_VALID,
  output logic [OWN_W-1:0]              SLOT_OWNER,
  output logic                          LINE_VALID,
  output logic [OWN_W-1:0]              LINE_OWNER,
  output logic [15:0]                   FRAMES_SENT,
  output logic [15:0]                   IDLE_SLOTS
);

  localparam int              CNT_W    = cnt_width(INPUTS_NUM);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INPUTS_NUM - 1);

  sched_state_e            state_q, state_d;
  logic [CNT_W-1:0]        cnt_q;
  logic [OWN_W-1:0]        ptr_q, ptr_next;
  logic                    boundary, arb_en;
  logic [REQ_NUM-1:0]      grant;
  logic [OWN_W-1:0]        grant_idx;
  logic                    any_grant;
  logic [INPUTS_NUM-1:0]   sel_word;

  logic [INPUTS_NUM-1:0]   par_p0;
  logic                    vld_p0;
  logic [OWN_W-1:0]        own_p0;
  logic                    fs_p0;
  logic [15:0]             frames_q, idle_q;

  logic [TREE_LATENCY-1:0] line_vld_p;
  logic [OWN_W-1:0]        line_own_p [TREE_LATENCY];

  rr_arbiter #(.REQ_NUM(REQ_NUM)) u_arb (
    .req       (REQ_VALID),
    .ptr       (ptr_q),
    .en        (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= ST_OFF;
    else       state_q <= state_d;
  end

  // Reset gates the arbiter so no READY escapes while the slot state is held clear.
  always_comb begin
    state_d  = state_q;
    boundary = 1'b0;
    case (state_q)
      ST_OFF: begin
        boundary = ENABLE;
        if (ENABLE) state_d = ST_RUN;
      end
      ST_RUN: begin
        boundary = (cnt_q == CNT_LAST);
        if (boundary && !ENABLE) state_d = ST_OFF;
      end
    endcase
    arb_en = boundary && ENABLE && !RESET;
  end

  always_comb begin
    sel_word = IDLE_WORD;
    for (int r = 0; r < REQ_NUM; r++) begin
      if (grant[r]) sel_word = REQ_DATA[r*INPUTS_NUM +: INPUTS_NUM];
    end
  end

  assign ptr_next  = (grant_idx == OWN_W'(REQ_NUM - 1)) ? '0 : grant_idx + OWN_W'(1);
  assign REQ_READY = grant;

  // Stage p0: slot register, loaded only at a slot boundary and held for the whole slot.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q    <= '0;
      ptr_q    <= '0;
      par_p0   <= IDLE_WORD;
      vld_p0   <= 1'b0;
      own_p0   <= '0;
      fs_p0    <= 1'b0;
      frames_q <= '0;
      idle_q   <= '0;
    end else if (boundary) begin
      cnt_q <= '0;
      fs_p0 <= ENABLE;
      if (!ENABLE) begin
        par_p0 <= IDLE_WORD;
        vld_p0 <= 1'b0;
      end else if (any_grant) begin
        par_p0   <= sel_word;
        vld_p0   <= 1'b1;
        own_p0   <= grant_idx;
        ptr_q    <= ptr_next;
        frames_q <= frames_q + 16'd1;
      end else begin
        par_p0 <= IDLE_WORD;
        vld_p0 <= 1'b0;
        idle_q <= idle_q + 16'd1;
      end
    end else begin
      fs_p0 <= 1'b0;
      if (state_q == ST_RUN) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Stages p1..pN: line tag delay matching the serializer tree; it keeps shifting in OFF.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      line_vld_p <= '0;
      for (int i = 0; i < TREE_LATENCY; i++) line_own_p[i] <= '0;
    end else begin
      line_vld_p[0] <= vld_p0;
      line_own_p[0] <= own_p0;
      for (int i = 1; i < TREE_LATENCY; i++) begin
        line_vld_p[i] <= line_vld_p[i-1];
        line_own_p[i] <= line_own_p[i-1];
      end
    end
  end

  assign PAR_OUT     = par_p0;
  assign SLOT_VALID  = vld_p0;
  assign SLOT_OWNER  = own_p0;
  assign FRAME_START = fs_p0;
  assign LINE_VALID  = line_vld_p[TREE_LATENCY-1];
  assign LINE_OWNER  = line_own_p[TREE_LATENCY-1];
  assign FRAMES_SENT = frames_q;
  assign IDLE_SLOTS  = idle_q;

endmodule
